// File: rtl/hit_resolver_pkg.sv
// Shared types for the hit resolver: box coordinates, FSM states and winner codes.
package hit_resolver_pkg;

    localparam int unsigned CoordW = 10;

    typedef logic [CoordW-1:0] coord_t;

    typedef enum logic [1:0] {
        StFight     = 2'd0,
        StHitstop   = 2'd1,
        StRoundOver = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        WinNone = 2'b00,
        WinP1   = 2'b01,
        WinP2   = 2'b10
    } winner_e;

    typedef struct packed {
        coord_t x1;
        coord_t x2;
        coord_t y1;
        coord_t y2;
        logic   active;
    } box_t;

    // Unsigned compare also rejects a mirrored box whose x1 wrapped below zero.
    function automatic logic box_usable(box_t b);
        return b.active && (b.x1 < b.x2) && (b.y1 < b.y2);
    endfunction

endpackage

// File: rtl/hit_resolver_box_overlap.sv
// Combinational strict-overlap test between one hitbox and one hurtbox.
module hit_resolver_box_overlap
    import hit_resolver_pkg::*;
(
    input  box_t hit_box,
    input  box_t hurt_box,
    output logic overlap
);

    // Strict compares: boxes that only share an edge do not overlap.
    assign overlap = box_usable(hit_box) && box_usable(hurt_box)
                  && (hit_box.x1 < hurt_box.x2) && (hurt_box.x1 < hit_box.x2)
                  && (hit_box.y1 < hurt_box.y2) && (hurt_box.y1 < hit_box.y2);

endmodule

// File: rtl/hit_resolver.sv
// Decides when hits land, enforces one hit per attack window, runs hitstop and keeps score.
module hit_resolver
    import hit_resolver_pkg::*;
#(
    parameter int unsigned WIN_POINTS     = 3,
    parameter int unsigned HITSTOP_FRAMES = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_tick,
    input  logic         round_reset,
    input  logic [9:0]   p1_hit_x1,
    input  logic [9:0]   p1_hit_x2,
    input  logic [9:0]   p1_hit_y1,
    input  logic [9:0]   p1_hit_y2,
    input  logic         p1_hit_active,
    input  logic [9:0]   p1_hurt_x1,
    input  logic [9:0]   p1_hurt_x2,
    input  logic [9:0]   p1_hurt_y1,
    input  logic [9:0]   p1_hurt_y2,
    input  logic         p1_hurt_active,
    input  logic [9:0]   p2_hit_x1,
    input  logic [9:0]   p2_hit_x2,
    input  logic [9:0]   p2_hit_y1,
    input  logic [9:0]   p2_hit_y2,
    input  logic         p2_hit_active,
    input  logic [9:0]   p2_hurt_x1,
    input  logic [9:0]   p2_hurt_x2,
    input  logic [9:0]   p2_hurt_y1,
    input  logic [9:0]   p2_hurt_y2,
    input  logic         p2_hurt_active,
    output logic         p1_got_hit,
    output logic         p2_got_hit,
    output logic         freeze,
    output logic [3:0]   p1_score,
    output logic [3:0]   p2_score,
    output logic         round_over,
    output logic [1:0]   winner
);

    localparam logic [3:0] WinPts      = 4'(WIN_POINTS);
    localparam logic [7:0] HitstopLoad = 8'(HITSTOP_FRAMES);

    box_t p1_hit_box, p1_hurt_box, p2_hit_box, p2_hurt_box;
    logic p1_on_p2, p2_on_p1;

    assign p1_hit_box  = '{x1: p1_hit_x1, x2: p1_hit_x2, y1: p1_hit_y1, y2: p1_hit_y2,
                           active: p1_hit_active};
    assign p1_hurt_box = '{x1: p1_hurt_x1, x2: p1_hurt_x2, y1: p1_hurt_y1, y2: p1_hurt_y2,
                           active: p1_hurt_active};
    assign p2_hit_box  = '{x1: p2_hit_x1, x2: p2_hit_x2, y1: p2_hit_y1, y2: p2_hit_y2,
                           active: p2_hit_active};
    assign p2_hurt_box = '{x1: p2_hurt_x1, x2: p2_hurt_x2, y1: p2_hurt_y1, y2: p2_hurt_y2,
                           active: p2_hurt_active};

    hit_resolver_box_overlap u_p1_on_p2 (
        .hit_box  (p1_hit_box),
        .hurt_box (p2_hurt_box),
        .overlap  (p1_on_p2)
    );

    hit_resolver_box_overlap u_p2_on_p1 (
        .hit_box  (p2_hit_box),
        .hurt_box (p1_hurt_box),
        .overlap  (p2_on_p1)
    );

    state_e     state_q, state_d;
    winner_e    winner_q, winner_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
    logic       p1_armed_q, p1_armed_d, p2_armed_q, p2_armed_d;
    logic       p1_prev_q, p2_prev_q;
    logic       p1_got_hit_q, p2_got_hit_q;

    logic       p1_can_hit, p2_can_hit;
    logic       p1_struck, p2_struck;
    logic [3:0] p1_score_inc, p2_score_inc;

    // A rising edge arms in the same cycle so a hit on the first active frame lands.
    assign p1_can_hit = p1_armed_q | (p1_hit_active & ~p1_prev_q);
    assign p2_can_hit = p2_armed_q | (p2_hit_active & ~p2_prev_q);

    assign p2_struck = (state_q == StFight) & p1_can_hit & p1_on_p2 & ~round_reset;
    assign p1_struck = (state_q == StFight) & p2_can_hit & p2_on_p1 & ~round_reset;

    assign p1_score_inc = (p1_score_q == WinPts) ? p1_score_q : p1_score_q + 4'd1;
    assign p2_score_inc = (p2_score_q == WinPts) ? p2_score_q : p2_score_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        cnt_d      = cnt_q;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        p1_armed_d = p1_armed_q;
        p2_armed_d = p2_armed_q;

        // Armed flags only evolve while fighting; frozen states hold them.
        if (state_q == StFight) begin
            p1_armed_d = p1_can_hit & p1_hit_active & ~p2_struck;
            p2_armed_d = p2_can_hit & p2_hit_active & ~p1_struck;
        end

        if (round_reset) begin
            p1_score_d = '0;
            p2_score_d = '0;
            winner_d   = WinNone;
        end else if (p2_struck && !p1_struck) begin
            p1_score_d = p1_score_inc;
        end else if (p1_struck && !p2_struck) begin
            p2_score_d = p2_score_inc;
        end

        case (state_q)
            StFight: begin
                if (p1_struck || p2_struck) begin
                    if (p2_struck && !p1_struck && p1_score_inc == WinPts) begin
                        state_d  = StRoundOver;
                        winner_d = WinP1;
                    end else if (p1_struck && !p2_struck && p2_score_inc == WinPts) begin
                        state_d  = StRoundOver;
                        winner_d = WinP2;
                    end else begin
                        state_d = StHitstop;
                        cnt_d   = HitstopLoad;
                    end
                end
            end
            StHitstop: begin
                if (frame_tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = '0;
                        state_d = StFight;
                    end
                end
            end
            StRoundOver: begin
                if (round_reset) begin
                    state_d    = StFight;
                    p1_armed_d = 1'b0;
                    p2_armed_d = 1'b0;
                end
            end
            default: state_d = StFight;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFight;
            winner_q     <= WinNone;
            cnt_q        <= '0;
            p1_score_q   <= '0;
            p2_score_q   <= '0;
            p1_armed_q   <= 1'b0;
            p2_armed_q   <= 1'b0;
            p1_prev_q    <= 1'b0;
            p2_prev_q    <= 1'b0;
            p1_got_hit_q <= 1'b0;
            p2_got_hit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            cnt_q        <= cnt_d;
            p1_score_q   <= p1_score_d;
            p2_score_q   <= p2_score_d;
            p1_armed_q   <= p1_armed_d;
            p2_armed_q   <= p2_armed_d;
            p1_prev_q    <= p1_hit_active;
            p2_prev_q    <= p2_hit_active;
            p1_got_hit_q <= p1_struck;
            p2_got_hit_q <= p2_struck;
        end
    end

    assign p1_got_hit = p1_got_hit_q;
    assign p2_got_hit = p2_got_hit_q;
    assign freeze     = (state_q != StFight);
    assign round_over = (state_q == StRoundOver);
    assign p1_score   = p1_score_q;
    assign p2_score   = p2_score_q;
    assign winner     = winner_q;

endmodule
